// File: rtl/axis_switch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axis_switch_pkg
// Purpose  : Shared types, widths and configuration check for axis_rr_switch.
// Revision : 1.0 - initial release
// ============================================================================
package axis_switch_pkg;

    localparam int c_NOUT_MAX = 8;
    localparam int c_PKT_W    = 16;
    localparam int c_GRP_W    = 16;
    localparam int c_FRM_W    = 32;
    localparam int c_FCNT_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    function automatic logic [c_FRM_W-1:0] group_beats(
        input logic [c_PKT_W-1:0] ps,
        input logic [c_GRP_W-1:0] pg
    );
        return c_FRM_W'(ps) * c_FRM_W'(pg);
    endfunction

    // A frame must hold a whole number of groups on every output.
    function automatic logic cfg_legal(
        input logic [c_PKT_W-1:0] ps,
        input logic [c_GRP_W-1:0] pg,
        input logic [c_FRM_W-1:0] fs
    );
        logic [c_FRM_W-1:0] gb;
        gb = group_beats(ps, pg);
        if (ps == '0 || pg == '0 || fs == '0) return 1'b0;
        if (gb > fs) return 1'b0;
        return ((fs % gb) == '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/axis_out_slot.sv
`default_nettype none
// ============================================================================
// Module   : axis_out_slot
// Purpose  : One-entry output register (data, last, destination) with
//            upstream space signal; refills in the same cycle it drains.
// Revision : 1.0 - initial release
// ============================================================================
module axis_out_slot
    import axis_switch_pkg::*;
#(
    parameter int DW = 128,
    parameter int SW = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  load,
    input  logic [DW-1:0]         in_data,
    input  logic                  in_last,
    input  logic [SW-1:0]         in_sel,
    input  logic [c_NOUT_MAX-1:0] dst_ready,
    output logic                  space,
    output logic                  ovalid,
    output logic [DW-1:0]         odata,
    output logic                  olast,
    output logic [SW-1:0]         osel
);

    localparam int c_IDX_W = $clog2(c_NOUT_MAX);

    logic               r_valid;
    logic               r_last;
    logic [DW-1:0]      r_data;
    logic [SW-1:0]      r_sel;
    logic [c_IDX_W-1:0] w_idx;
    logic               w_drain;

    assign w_idx   = c_IDX_W'(r_sel);
    assign w_drain = r_valid & dst_ready[w_idx];
    assign space   = ~r_valid | dst_ready[w_idx];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_data  <= '0;
            r_sel   <= '0;
        end else if (load) begin
            r_valid <= 1'b1;
            r_last  <= in_last;
            r_data  <= in_data;
            r_sel   <= in_sel;
        end else if (w_drain) begin
            r_valid <= 1'b0;
        end
    end

    assign ovalid = r_valid;
    assign odata  = r_data;
    assign olast  = r_last;
    assign osel   = r_sel;

endmodule
`default_nettype wire

// File: rtl/axis_rr_switch.sv
`default_nettype none
// ============================================================================
// Module   : axis_rr_switch
// Purpose  : AXI-Stream round-robin demux; routes packet groups over NOUT
//            outputs and inserts tlast at each per-output frame boundary.
// Revision : 1.0 - initial release
// ============================================================================
module axis_rr_switch
    import axis_switch_pkg::*;
#(
    parameter  int DW   = 128,
    parameter  int NOUT = 4,
    localparam int SW   = $clog2(NOUT)
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 enable,
    input  logic [c_PKT_W-1:0]   packet_size,
    input  logic [c_GRP_W-1:0]   pp_group,
    input  logic [c_FRM_W-1:0]   frame_size,
    output logic                 cfg_err,
    output logic                 running,
    output logic [SW-1:0]        cur_sel,
    output logic [c_FCNT_W-1:0]  frame_cnt,
    input  logic [DW-1:0]        s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    output logic [NOUT*DW-1:0]   m_axis_tdata,
    output logic [NOUT-1:0]      m_axis_tvalid,
    output logic [NOUT-1:0]      m_axis_tlast,
    input  logic [NOUT-1:0]      m_axis_tready
);

    localparam logic [c_FRM_W-1:0] c_ONE = 1;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [c_FRM_W-1:0]      r_frame_size;
    logic [c_FRM_W-1:0]      r_group_beats;
    logic [c_FRM_W-1:0]      r_beat_cnt;
    logic [c_FRM_W-1:0]      r_fpos [NOUT];
    logic [SW-1:0]           r_sel;
    logic [c_FCNT_W-1:0]     r_frame_cnt;
    logic                    r_cfg_err;

    logic                    w_start;
    logic                    w_reject;
    logic                    w_cfg_ok;
    logic                    w_accept;
    logic                    w_group_end;
    logic                    w_last;
    logic                    w_space;
    logic [c_FRM_W-1:0]      w_group_beats;
    logic [c_FRM_W-1:0]      w_fpos_sel;
    logic [c_FRM_W-1:0]      w_fpos_inc;
    logic [c_NOUT_MAX-1:0]   w_ready_pad;
    logic                    w_ovalid;
    logic                    w_olast;
    logic [DW-1:0]           w_odata;
    logic [SW-1:0]           w_osel;

    assign w_group_beats = group_beats(packet_size, pp_group);
    assign w_cfg_ok      = cfg_legal(packet_size, pp_group, frame_size);
    assign w_fpos_sel    = r_fpos[r_sel];
    assign w_fpos_inc    = w_fpos_sel + r_group_beats;
    assign w_group_end   = (r_beat_cnt == r_group_beats - c_ONE);
    assign w_last        = (w_fpos_sel + r_beat_cnt + c_ONE == r_frame_size);
    assign s_axis_tready = (r_state != ST_IDLE) & w_space;
    assign w_accept      = s_axis_tvalid & s_axis_tready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Dropping enable exactly on a group boundary skips STOP entirely.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_reject    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    if (w_cfg_ok) begin
                        w_start     = 1'b1;
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_reject    = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    if (w_accept ? w_group_end : (r_beat_cnt == '0))
                        w_state_nxt = ST_IDLE;
                    else
                        w_state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_accept && w_group_end) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_frame_size  <= '0;
            r_group_beats <= '0;
            r_beat_cnt    <= '0;
            r_sel         <= '0;
            r_frame_cnt   <= '0;
            r_cfg_err     <= 1'b0;
            for (int i = 0; i < NOUT; i++) r_fpos[i] <= '0;
        end else begin
            if (w_start) begin
                r_frame_size  <= frame_size;
                r_group_beats <= w_group_beats;
                r_beat_cnt    <= '0;
                r_sel         <= '0;
                r_cfg_err     <= 1'b0;
                for (int i = 0; i < NOUT; i++) r_fpos[i] <= '0;
            end else if (w_reject) begin
                r_cfg_err     <= 1'b1;
            end
            if (w_accept) begin
                if (w_group_end) begin
                    r_beat_cnt    <= '0;
                    r_fpos[r_sel] <= (w_fpos_inc == r_frame_size) ? '0 : w_fpos_inc;
                    r_sel         <= (r_sel == SW'(NOUT-1)) ? '0 : r_sel + SW'(1);
                end else begin
                    r_beat_cnt    <= r_beat_cnt + c_ONE;
                end
                if (w_last) r_frame_cnt <= r_frame_cnt + c_FCNT_W'(1);
            end
        end
    end

    always_comb begin
        w_ready_pad              = '0;
        w_ready_pad[NOUT-1:0]    = m_axis_tready;
    end

    axis_out_slot #(
        .DW (DW),
        .SW (SW)
    ) u_slot (
        .clk       (clk),
        .resetn    (resetn),
        .load      (w_accept),
        .in_data   (s_axis_tdata),
        .in_last   (w_last),
        .in_sel    (r_sel),
        .dst_ready (w_ready_pad),
        .space     (w_space),
        .ovalid    (w_ovalid),
        .odata     (w_odata),
        .olast     (w_olast),
        .osel      (w_osel)
    );

    for (genvar i = 0; i < NOUT; i++) begin : g_out
        assign m_axis_tvalid[i]          = w_ovalid & (w_osel == SW'(i));
        assign m_axis_tlast[i]           = m_axis_tvalid[i] & w_olast;
        assign m_axis_tdata[i*DW +: DW]  = m_axis_tvalid[i] ? w_odata : '0;
    end

    assign cfg_err   = r_cfg_err;
    assign running   = (r_state != ST_IDLE);
    assign cur_sel   = r_sel;
    assign frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire
